ring_router_mux_rr: RTL and testbench

Parametrised N-input worm-preserving multiplexer for the debug interconnect ring router. It merges NUM_IN DII flit streams (ring input plus one or more local ports) onto one output. Once a worm's first flit is granted, that input owns the output until its last flit transfers. Arbitration between new worms is round-robin, an optional output register stage breaks timing paths, and orphan flits are flagged.

---
 rtl/ring_router_mux_rr.sv | 186 ++++++++++++++++++
 tb/tb_ring_router_mux_rr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_mux_rr.sv
// ring_router_mux_rr
//   Worm-preserving N:1 multiplexer for the debug interconnect ring router.
//   It merges NUM_IN flit streams onto one output. Input 0 is conventionally
//   the ring input. A granted worm keeps the output until its last flit has
//   transferred. New worms are arbitrated round-robin. Valid flits that are
//   not first flits and arrive while unlocked are flagged as orphans and are
//   held stalled. An optional 2-entry skid buffer registers the output path.
//
// Parameters
//   NUM_IN      number of input channels (>= 2)
//   DATA_WIDTH  flit data width
//   OUT_REG     0: combinational output path; 1: registered through a skid buffer
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   in_data     packed flit data; input i is in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_first    first-flit marker per input
//   in_last     last-flit marker per input
//   in_valid    flit valid per input
//   in_ready    flit accepted per input
//   out_data    output flit data
//   out_first   output first-flit marker
//   out_last    output last-flit marker
//   out_valid   output flit valid
//   out_ready   downstream accepts the flit
//   err_orphan  high in an IDLE cycle where only non-first valid flits are present
module ring_router_mux_rr #(
    parameter int NUM_IN     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_first,
    input  logic [NUM_IN-1:0]            in_last,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_orphan
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  first;
        logic                  last;
    } flit_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel;

    logic [DATA_WIDTH-1:0] in_word [NUM_IN];

    logic             found;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] cur;
    logic             active;
    logic             sready;
    logic             st_valid;
    logic             st_xfer;
    flit_t            st_flit;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign in_word[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_IN - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Round-robin search for a first flit, starting at rr_ptr.
    always_comb begin
        logic [IDX_W:0] pos;
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no latch).
        found = 1'b0;
        grant = rr_ptr;
        pos   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_IN))
                pos = pos - (IDX_W+1)'(NUM_IN);
            if (!found && in_valid[pos[IDX_W-1:0]] && in_first[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                grant = pos[IDX_W-1:0];
            end
        end
    end

    // Gating with rst keeps in_ready/out_valid low while reset is applied.
    assign cur      = (state == LOCKED) ? sel : grant;
    assign active   = !rst && ((state == LOCKED) || found);
    assign st_valid = active && in_valid[cur];
    assign st_flit  = '{data: in_word[cur], first: in_first[cur], last: in_last[cur]};
    assign st_xfer  = st_valid && sready;

    always_comb begin
        in_ready = '0;
        if (active)
            in_ready[cur] = sready;
    end

    assign err_orphan = !rst && (state == IDLE) && !found && |(in_valid & ~in_first);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values.
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_xfer) begin
                        if (st_flit.last) begin
                            rr_ptr <= next_idx(grant);
                        end else begin
                            state <= LOCKED;
                            sel   <= grant;
                        end
                    end
                end
                LOCKED: begin
                    if (st_xfer && st_flit.last) begin
                        state  <= IDLE;
                        rr_ptr <= next_idx(sel);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if (OUT_REG == 0) begin : g_comb
        assign sready    = out_ready;
        assign out_valid = st_valid;
        assign out_data  = st_flit.data;
        assign out_first = st_flit.first;
        assign out_last  = st_flit.last;
    end else begin : g_skid
        flit_t      mem [2];
        logic       wr_ptr;
        logic       rd_ptr;
        logic [1:0] count;
        logic       pop;

        // sready comes from the occupancy register only, so out_ready never
        // reaches in_ready combinationally; two entries absorb the stall.
        assign sready    = (count != 2'd2);
        assign out_valid = (count != 2'd0);
        assign pop       = out_valid && out_ready;
        assign out_data  = mem[rd_ptr].data;
        assign out_first = mem[rd_ptr].first;
        assign out_last  = mem[rd_ptr].last;

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (st_xfer) wr_ptr <= ~wr_ptr;
                if (pop)     rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, st_xfer} - {1'b0, pop};
            end
        end

        // NOTE: storage is not reset; count gates out_valid, so stale
        // entries are never observed.
        always_ff @(posedge clk) begin
            if (st_xfer)
                mem[wr_ptr] <= st_flit;
        end
    end

endmodule

// File: tb/tb_ring_router_mux_rr.sv
// Directed testbench for ring_router_mux_rr. One instance with three inputs
// and a combinational output, one with two inputs and the skid buffer.
module tb_ring_router_mux_rr;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // combinational instance, NUM_IN = 3
    logic [3*DW-1:0] c_data;
    logic [2:0]      c_first, c_last, c_valid, c_ready;
    logic [DW-1:0]   c_odata;
    logic            c_ofirst, c_olast, c_ovalid, c_oready, c_err;

    // registered instance, NUM_IN = 2
    logic [2*DW-1:0] r_data;
    logic [1:0]      r_first, r_last, r_valid, r_ready;
    logic [DW-1:0]   r_odata;
    logic            r_ofirst, r_olast, r_ovalid, r_oready, r_err;

    ring_router_mux_rr #(.NUM_IN(3), .DATA_WIDTH(DW), .OUT_REG(0)) u_dut_c (
        .clk(clk), .rst(rst),
        .in_data(c_data), .in_first(c_first), .in_last(c_last),
        .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_odata), .out_first(c_ofirst), .out_last(c_olast),
        .out_valid(c_ovalid), .out_ready(c_oready), .err_orphan(c_err)
    );

    ring_router_mux_rr #(.NUM_IN(2), .DATA_WIDTH(DW), .OUT_REG(1)) u_dut_r (
        .clk(clk), .rst(rst),
        .in_data(r_data), .in_first(r_first), .in_last(r_last),
        .in_valid(r_valid), .in_ready(r_ready),
        .out_data(r_odata), .out_first(r_ofirst), .out_last(r_olast),
        .out_valid(r_ovalid), .out_ready(r_oready), .err_orphan(r_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic c_drive(input int i, input logic v, input logic f, input logic l,
                           input logic [DW-1:0] d);
        c_valid[i]          = v;
        c_first[i]          = f;
        c_last[i]           = l;
        c_data[i*DW +: DW]  = d;
    endtask

    task automatic c_idle;
        c_valid = '0;
        c_first = '0;
        c_last  = '0;
        c_data  = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    logic [DW-1:0] exp2 [8] = '{16'h0000, 16'h0001, 16'h1000, 16'h1001,
                                16'h2000, 16'h2001, 16'h0100, 16'h0101};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fi [3];
        int wn [3];
        int got_n;
        int s, rx, cnt;
        logic exp_ready, push, pop;

        c_idle;
        c_oready = 1'b1;
        r_valid  = '0; r_first = '0; r_last = '0; r_data = '0;
        r_oready = 1'b1;
        rst      = 1'b1;

        // ---------------- reset values ----------------
        tick;
        tick;
        check("rst_c_ovalid", c_ovalid, 0);
        check("rst_c_ready",  c_ready,  0);
        check("rst_c_err",    c_err,    0);
        check("rst_r_ovalid", r_ovalid, 0);
        check("rst_r_ready",  r_ready,  0);
        check("rst_r_err",    r_err,    0);
        c_drive(0, 1, 1, 1, 16'h1234);
        #1;
        check("rst_held_ready",  c_ready,  0);
        check("rst_held_ovalid", c_ovalid, 0);
        c_idle;
        rst = 1'b0;
        tick;

        // ---------------- 3-flit worm on input 0 ----------------
        c_drive(0, 1, 1, 0, 16'hA000);
        #1;
        check("t1_a0_valid", c_ovalid, 1);
        check("t1_a0_data",  c_odata,  16'hA000);
        check("t1_a0_first", c_ofirst, 1);
        check("t1_a0_ready", c_ready,  3'b001);
        tick;
        c_drive(0, 1, 0, 0, 16'hA001);
        #1;
        check("t1_a1_data",  c_odata,  16'hA001);
        check("t1_a1_first", c_ofirst, 0);
        check("t1_a1_ready", c_ready,  3'b001);
        tick;
        c_drive(0, 1, 0, 1, 16'hA002);
        #1;
        check("t1_a2_data", c_odata, 16'hA002);
        check("t1_a2_last", c_olast, 1);
        tick;
        // rr_ptr is now 1: input 1 wins over input 0
        c_drive(0, 1, 1, 1, 16'hB000);
        c_drive(1, 1, 1, 1, 16'hC000);
        #1;
        check("t1_rr_ready", c_ready, 3'b010);
        check("t1_rr_data",  c_odata, 16'hC000);
        tick;
        c_drive(1, 0, 0, 0, 16'h0000);
        #1;
        check("t1_b_ready", c_ready, 3'b001);
        check("t1_b_data",  c_odata, 16'hB000);
        tick;
        c_idle;
        #1;
        check("t1_idle_ovalid", c_ovalid, 0);

        // ---------------- three competing 2-flit worms ----------------
        do_reset;
        for (int i = 0; i < 3; i++) begin
            fi[i] = 0;
            wn[i] = 0;
        end
        got_n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            for (int i = 0; i < 3; i++)
                c_drive(i, 1, fi[i] == 0, fi[i] == 1, {4'(i), 4'(wn[i]), 8'(fi[i])});
            #1;
            if (c_ovalid && c_oready) begin
                check($sformatf("t2_flit%0d", got_n), c_odata, exp2[got_n]);
                got_n++;
            end
            for (int i = 0; i < 3; i++) begin
                if (c_ready[i]) begin
                    if (fi[i] == 1) begin
                        fi[i] = 0;
                        wn[i]++;
                    end else begin
                        fi[i] = 1;
                    end
                end
            end
            tick;
        end
        check("t2_count", got_n, 8);
        c_idle;

        // ---------------- lock holds off a new first flit ----------------
        do_reset;
        c_drive(1, 1, 1, 0, 16'hD000);
        #1;
        check("t3_d0_ready", c_ready, 3'b010);
        tick;
        c_drive(1, 1, 0, 0, 16'hD001);
        c_drive(0, 1, 1, 1, 16'hE000);
        #1;
        check("t3_d1_ready", c_ready, 3'b010);
        check("t3_d1_data",  c_odata, 16'hD001);
        tick;
        c_drive(1, 1, 0, 1, 16'hD002);
        #1;
        check("t3_d2_ready", c_ready, 3'b010);
        check("t3_d2_last",  c_olast, 1);
        tick;
        c_drive(1, 0, 0, 0, 16'h0000);
        #1;
        check("t3_e0_ready", c_ready, 3'b001);
        check("t3_e0_data",  c_odata, 16'hE000);
        check("t3_e0_first", c_ofirst, 1);
        tick;
        c_idle;

        // ---------------- orphan detection ----------------
        c_drive(1, 1, 0, 0, 16'h0BAD);
        #1;
        check("t5_orph_err",    c_err,    1);
        check("t5_orph_ready",  c_ready,  0);
        check("t5_orph_ovalid", c_ovalid, 0);
        tick;
        check("t5_orph_err2", c_err, 1);
        tick;
        c_drive(0, 1, 1, 1, 16'h5000);
        #1;
        check("t5_single_err",   c_err,    0);
        check("t5_single_ready", c_ready,  3'b001);
        check("t5_single_data",  c_odata,  16'h5000);
        check("t5_single_valid", c_ovalid, 1);
        tick;
        c_drive(0, 0, 0, 0, 16'h0000);
        #1;
        check("t5_orph_err3", c_err, 1);
        tick;
        c_idle;

        // ---------------- reset in the middle of a 4-flit worm ----------------
        do_reset;
        c_drive(2, 1, 1, 0, 16'h6000);
        #1;
        check("t6_f0_ready", c_ready, 3'b100);
        check("t6_f0_data",  c_odata, 16'h6000);
        tick;
        c_drive(2, 1, 0, 0, 16'h6001);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", c_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        check("t6_post_ovalid", c_ovalid, 0);
        check("t6_post_ready",  c_ready,  0);
        check("t6_post_err",    c_err,    1);
        tick;
        c_drive(2, 1, 0, 0, 16'h6002);
        #1;
        check("t6_f2_err",   c_err,   1);
        check("t6_f2_ready", c_ready, 0);
        tick;
        c_drive(2, 1, 0, 1, 16'h6003);
        #1;
        check("t6_f3_err", c_err, 1);
        tick;
        c_idle;
        // rr_ptr back at 0: input 1 is the first candidate found
        c_drive(1, 1, 1, 1, 16'h7100);
        c_drive(2, 1, 1, 1, 16'h7200);
        #1;
        check("t6_ptr_ready", c_ready, 3'b010);
        check("t6_ptr_data",  c_odata, 16'h7100);
        tick;
        c_idle;

        // ---------------- skid buffer, out_ready 1,0,0 repeating ----------------
        do_reset;
        s   = 0;
        rx  = 0;
        cnt = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            r_oready = (cyc % 3 == 0);
            if (s < 8) begin
                r_valid = 2'b01;
                r_first = {1'b0, s == 0};
                r_last  = {1'b0, s == 7};
                r_data  = {16'h0000, 16'hF000 + 16'(s)};
            end else begin
                r_valid = '0;
                r_first = '0;
                r_last  = '0;
            end
            #1;
            exp_ready = (s < 8) && (cnt < 2);
            push      = exp_ready;
            pop       = (cnt > 0) && r_oready;
            check($sformatf("t4_ready_c%0d", cyc),  r_ready,  {1'b0, exp_ready});
            check($sformatf("t4_ovalid_c%0d", cyc), r_ovalid, cnt > 0);
            if (pop) begin
                check($sformatf("t4_data%0d", rx),  r_odata,  16'hF000 + 16'(rx));
                check($sformatf("t4_first%0d", rx), r_ofirst, rx == 0);
                check($sformatf("t4_last%0d", rx),  r_olast,  rx == 7);
                rx++;
            end
            if (push) s++;
            cnt = cnt + int'(push) - int'(pop);
            tick;
        end
        check("t4_rx_count", rx, 8);
        r_valid = '0;
        check("t4_err", r_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
